// File: rtl/fsm_session_arbiter.sv
// fsm_session_arbiter: round-robin session arbiter sharing one Mealy FSM between two requesters
module fsm_session_arbiter #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [1:0]       req0_ab_i,
  input  logic             req0_last_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [1:0]       req1_ab_i,
  input  logic             req1_last_i,
  output logic             req1_ready_o,
  output logic             fsm_a_o,
  output logic             fsm_b_o,
  output logic             fsm_rst_o,
  input  logic [1:0]       fsm_y_i,
  output logic             resp_valid_o,
  output logic             resp_id_o,
  output logic [1:0]       resp_y_o,
  output logic             resp_last_o,
  output logic             abort_o,
  output logic             abort_id_o,
  output logic [CNT_W-1:0] sess_cnt0_o,
  output logic [CNT_W-1:0] sess_cnt1_o
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d, rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             a_q, a_d, b_q, b_d, frst_q, frst_d;
  logic             pid_q, pid_d, plast_q, plast_d;
  logic             rv_q, rv_d, rid_q, rid_d, rlast_q, rlast_d;
  logic [1:0]       ry_q, ry_d;
  logic             abort_q, abort_d, aid_q, aid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       serving, own_valid, own_last, accept, done, any_v, both_v;
  logic [1:0] own_ab;

  assign serving   = state_q == SERVE;
  assign own_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign own_ab    = owner_q ? req1_ab_i : req0_ab_i;
  assign own_last  = owner_q ? req1_last_i : req0_last_i;
  assign accept    = serving & own_valid;
  assign done      = own_last | (len_q == LEN_W'(MAX_LEN - 1));
  assign any_v     = req0_valid_i | req1_valid_i;
  assign both_v    = req0_valid_i & req1_valid_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    len_d   = (accept & ~done) ? len_q + LEN_W'(1) : '0;
    a_d     = accept ? own_ab[1] : a_q;
    b_d     = accept ? own_ab[0] : b_q;
    frst_d  = ~accept;
    pid_d   = owner_q;
    plast_d = accept & done;
    // the response pipeline follows the symbol applied during the previous cycle
    rv_d    = ~frst_q;
    rid_d   = pid_q;
    ry_d    = fsm_y_i;
    rlast_d = plast_q;
    abort_d = serving & ~own_valid;
    aid_d   = abort_d ? owner_q : aid_q;
    cnt0_d  = cnt0_q + CNT_W'(accept & done & ~owner_q);
    cnt1_d  = cnt1_q + CNT_W'(accept & done & owner_q);
    case (state_q)
      IDLE: begin
        state_d = any_v ? SERVE : IDLE;
        owner_d = any_v ? (both_v ? rr_q : req1_valid_i) : owner_q;
        rr_d    = both_v ? ~rr_q : rr_q;
      end
      SERVE:   state_d = (accept & ~done) ? SERVE : GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      len_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      frst_q  <= 1'b1;
      pid_q   <= 1'b0;
      plast_q <= 1'b0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      ry_q    <= 2'b00;
      rlast_q <= 1'b0;
      abort_q <= 1'b0;
      aid_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      frst_q  <= frst_d;
      pid_q   <= pid_d;
      plast_q <= plast_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      ry_q    <= ry_d;
      rlast_q <= rlast_d;
      abort_q <= abort_d;
      aid_q   <= aid_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign req0_ready_o = serving & ~owner_q;
  assign req1_ready_o = serving & owner_q;
  assign fsm_a_o      = a_q;
  assign fsm_b_o      = b_q;
  assign fsm_rst_o    = frst_q;
  assign resp_valid_o = rv_q;
  assign resp_id_o    = rid_q;
  assign resp_y_o     = ry_q;
  assign resp_last_o  = rlast_q;
  assign abort_o      = abort_q;
  assign abort_id_o   = aid_q;
  assign sess_cnt0_o  = cnt0_q;
  assign sess_cnt1_o  = cnt1_q;
endmodule

// File: tb/tb_fsm_session_arbiter.sv
// tb_fsm_session_arbiter: scoreboard bench with a behavioural stand-in for the shared Mealy FSM
module tb_fsm_session_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_last = '0;
  logic [1:0] req_ab [2];
  logic [1:0] rdy;
  logic       fsm_a, fsm_b, fsm_rst;
  logic [1:0] fsm_y;
  logic       resp_valid, resp_id, resp_last, abort, abort_id;
  logic [1:0] resp_y;
  logic [7:0] cnt0, cnt1;

  typedef struct packed {logic id; logic [1:0] y; logic last;} resp_t;
  resp_t sb [$];
  logic  exp_abort [$];
  logic  grants [$];
  int    exp_cnt [2];
  int    waits [2][32];
  int    checks = 0;
  int    errors = 0;
  logic [1:0] fsm_st;

  always #5 clk = ~clk;

  fsm_session_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req_valid[0]), .req0_ab_i(req_ab[0]), .req0_last_i(req_last[0]), .req0_ready_o(rdy[0]),
    .req1_valid_i(req_valid[1]), .req1_ab_i(req_ab[1]), .req1_last_i(req_last[1]), .req1_ready_o(rdy[1]),
    .fsm_a_o(fsm_a), .fsm_b_o(fsm_b), .fsm_rst_o(fsm_rst), .fsm_y_i(fsm_y),
    .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_y_o(resp_y), .resp_last_o(resp_last),
    .abort_o(abort), .abort_id_o(abort_id), .sess_cnt0_o(cnt0), .sess_cnt1_o(cnt1)
  );

  // stand-in FSM: 10 enters S2, 11 returns to S0; in S2 the output a bit is inverted
  function automatic logic [1:0] fy(input logic [1:0] st, input logic [1:0] ab);
    return st == 2'd2 ? ab ^ 2'b10 : ab;
  endfunction

  function automatic logic [1:0] fn(input logic [1:0] st, input logic [1:0] ab);
    return ab == 2'b10 ? 2'd2 : ab == 2'b11 ? 2'd0 : st;
  endfunction

  always_ff @(posedge clk) fsm_st <= fsm_rst ? 2'd0 : fn(fsm_st, {fsm_a, fsm_b});
  assign fsm_y = fy(fsm_st, {fsm_a, fsm_b});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("resp_id", resp_id, e.id);
          chk("resp_y", resp_y, e.y);
          chk("resp_last", resp_last, e.last);
        end
      end
      if (abort) begin
        if (exp_abort.size() == 0) chk("abort_unexpected", 1, 0);
        else chk("abort_id", abort_id, exp_abort.pop_front());
      end
    end
  end

  task automatic send(input int id, input logic [63:0] pat, input int n, input bit use_last, input bit drop);
    logic [1:0] st = 0;
    int c = 0;
    int w;
    logic lst;
    for (int i = 0; i < n; i++) begin
      req_valid[id] = 1'b1;
      req_ab[id] = pat[2*i +: 2];
      req_last[id] = use_last && (i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!rdy[id] && w < 100);
      if (!rdy[id]) begin
        chk("ready_timeout", 0, 1);
        req_valid[id] = 1'b0;
        return;
      end
      waits[id][i] = w;
      if (c == 0) grants.push_back(id[0]);
      lst = req_last[id] || (c == 15);
      sb.push_back('{id[0], fy(st, req_ab[id]), lst});
      st = lst ? 2'd0 : fn(st, req_ab[id]);
      c = lst ? 0 : c + 1;
      if (lst) exp_cnt[id]++;
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
    if (drop) exp_abort.push_back(id[0]);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    req_ab[0] = 2'b00;
    req_ab[1] = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fsm_rst", fsm_rst, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_abort", {abort, abort_id}, 0);
    chk("rst_fsm_ab", {fsm_a, fsm_b}, 0);
    chk("rst_cnts", {cnt0, cnt1}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 64'h1, 2, 1, 0);
    drain();
    chk("t1_cnt0", cnt0, exp_cnt[0]);
    chk("t1_fsm_rst", fsm_rst, 1);
    send(0, 64'hE, 2, 1, 0);
    drain();
    chk("t2_cnt0", cnt0, exp_cnt[0]);
    grants.delete();
    for (int r = 0; r < 2; r++) begin
      fork
        send(0, 64'h1, 1, 1, 0);
        send(1, 64'h1, 1, 1, 0);
      join
      drain();
    end
    chk("t3_grant_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("t3_grant0", grants[0], 0);
      chk("t3_grant1", grants[1], 1);
      chk("t3_grant2", grants[2], 1);
      chk("t3_grant3", grants[3], 0);
    end
    chk("t3_cnt0", cnt0, exp_cnt[0]);
    chk("t3_cnt1", cnt1, exp_cnt[1]);
    send(1, 64'h0, 16, 0, 0);
    drain();
    chk("t4_cnt1", cnt1, exp_cnt[1]);
    chk("t4_sb_empty", sb.size(), 0);
    send(1, 64'h0, 18, 1, 0);
    drain();
    chk("t4_cnt1_trunc", cnt1, exp_cnt[1]);
    chk("t4_wait_in_session", waits[1][1], 1);
    chk("t4_wait_after_trunc", waits[1][16], 3);
    grants.delete();
    fork
      send(0, 64'h9, 2, 0, 1);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 64'h1, 1, 1, 0);
      end
    join
    drain();
    chk("t5_cnt0", cnt0, exp_cnt[0]);
    chk("t5_cnt1", cnt1, exp_cnt[1]);
    chk("t5_grants", grants.size(), 2);
    if (grants.size() == 2) chk("t5_next_grant", grants[1], 1);
    chk("t5_abort_seen", exp_abort.size(), 0);
    req_valid[0] = 1'b1;
    req_ab[0] = 2'b11;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rdy[0] && w < 100);
    chk("t6_ready", rdy[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_fsm_rst", fsm_rst, 1);
    chk("t6_abort", abort, 0);
    chk("t6_ready0", rdy, 0);
    chk("t6_fsm_ab", {fsm_a, fsm_b}, 0);
    chk("t6_cnts", {cnt0, cnt1}, 0);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    drain();
    chk("end_sb_empty", sb.size(), 0);
    chk("end_abort_empty", exp_abort.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
